// File: rtl/phase_pkg.sv
// Shared phase and sequencer-state types for the phase sequencer and sequence controller.
package phase_pkg;

    typedef enum logic [1:0] {
        FETCH   = 2'b00,
        DECODE  = 2'b01,
        EXECUTE = 2'b10,
        UPDATE  = 2'b11
    } phase_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } seq_state_t;

    function automatic phase_t next_phase(input phase_t p);
        unique case (p)
            FETCH:   return DECODE;
            DECODE:  return EXECUTE;
            EXECUTE: return UPDATE;
            default: return FETCH;
        endcase
    endfunction

    // Only the memory-facing phases can be stretched by wait states.
    function automatic logic needs_mem(input phase_t p);
        return (p == FETCH) || (p == EXECUTE);
    endfunction

endpackage

// File: rtl/phase_sequencer_wait_timer.sv
// Per-phase wait-state counter; expired flags that the stall budget WAIT_MAX is used up.
module wait_timer #(
    parameter int WAIT_MAX = 7
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int CNT_W = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == CNT_W'(WAIT_MAX));

endmodule

// File: rtl/phase_sequencer.sv
// Instruction phase generator with run/pause/step/halt control and a retired-instruction counter.
// Define PHASER_WAIT_EN to enable MEM_RDY wait states and the wait-state timeout.
module phase_sequencer
    import phase_pkg::*;
#(
    parameter int WAIT_MAX = 7,
    parameter int ICOUNT_W = 16
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                EN,
    input  logic                STEP_MODE,
    input  logic                STEP,
    input  logic                MEM_RDY,
    input  logic                HALT_REQ,
    output logic [1:0]          PHASE,
    output logic                PHASE_STB,
    output logic                RUNNING,
    output logic                HALTED,
    output logic                TIMEOUT,
    output logic [ICOUNT_W-1:0] INSTR_CNT
);

    seq_state_t          state_q, state_d;
    phase_t              phase_q, phase_d;
    logic                stb_q, stb_d;
    logic                halt_pend_q, halt_pend_d;
    logic [ICOUNT_W-1:0] cnt_q, cnt_d;
    logic                stall;
    logic                timeout_evt;

`ifdef PHASER_WAIT_EN
    logic timeout_q, timeout_d;
    logic expired;
    logic wt_clr, wt_inc;

    assign stall       = (state_q == RUN) && needs_mem(phase_q) && !MEM_RDY;
    assign timeout_evt = stall && expired;
    assign wt_inc      = stall && !expired;
    // Any cycle that is not a counted stall is followed by a fresh phase (or no phase at all).
    assign wt_clr      = !wt_inc;

    wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk     (CLK),
        .rst_n   (RST_N),
        .clr     (wt_clr),
        .inc     (wt_inc),
        .expired (expired)
    );

    always_comb begin
        timeout_d = timeout_q | timeout_evt;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end

    assign TIMEOUT = timeout_q;
`else
    logic unused_cfg;

    assign stall       = 1'b0;
    assign timeout_evt = 1'b0;
    assign TIMEOUT     = 1'b0;
    assign unused_cfg  = MEM_RDY ^ (WAIT_MAX != 0);
`endif

    always_comb begin
        // NOTE: every variable gets a default first, so no branch can infer a latch.
        state_d     = state_q;
        phase_d     = phase_q;
        stb_d       = 1'b0;
        halt_pend_d = halt_pend_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            IDLE: begin
                phase_d = FETCH;
                if (EN && (!STEP_MODE || STEP)) begin
                    state_d = RUN;
                    stb_d   = 1'b1;
                end
            end
            RUN: begin
                halt_pend_d = halt_pend_q | HALT_REQ;
                if (timeout_evt) begin
                    state_d = HALT;
                    phase_d = FETCH;
                end else if (!stall) begin
                    phase_d = next_phase(phase_q);
                    stb_d   = 1'b1;
                    // Instruction boundary: retire, then decide whether to keep running.
                    if (phase_q == UPDATE) begin
                        cnt_d = cnt_q + ICOUNT_W'(1);
                        if (halt_pend_d) begin
                            state_d = HALT;
                            stb_d   = 1'b0;
                        end else if (!EN || STEP_MODE) begin
                            state_d = IDLE;
                            stb_d   = 1'b0;
                        end
                    end
                end
            end
            HALT: begin
                phase_d = FETCH;
            end
            default: begin
                state_d = IDLE;
                phase_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            phase_q     <= FETCH;
            stb_q       <= 1'b0;
            halt_pend_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            stb_q       <= stb_d;
            halt_pend_q <= halt_pend_d;
            cnt_q       <= cnt_d;
        end
    end

    assign PHASE     = phase_q;
    assign PHASE_STB = stb_q;
    assign RUNNING   = (state_q == RUN);
    assign HALTED    = (state_q == HALT);
    assign INSTR_CNT = cnt_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer: randomized stalls and controls against a phase-list model.
module tb_phase_sequencer;

    localparam int WAIT_MAX = 7;
    localparam int ICOUNT_W = 16;

    logic                CLK = 1'b0;
    logic                RST_N = 1'b1;
    logic                EN = 1'b0;
    logic                STEP_MODE = 1'b0;
    logic                STEP = 1'b0;
    logic                MEM_RDY = 1'b1;
    logic                HALT_REQ = 1'b0;
    logic [1:0]          PHASE;
    logic                PHASE_STB, RUNNING, HALTED, TIMEOUT;
    logic [ICOUNT_W-1:0] INSTR_CNT;
    logic [1:0]          b_phase;
    logic                b_stb, b_running, b_halted, b_timeout;
    logic [1:0]          b_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int exp_cnt   = 0;
    bit exp_to    = 1'b0;

    phase_sequencer #(.WAIT_MAX(WAIT_MAX), .ICOUNT_W(ICOUNT_W)) dut (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .STEP_MODE(STEP_MODE), .STEP(STEP),
        .MEM_RDY(MEM_RDY), .HALT_REQ(HALT_REQ), .PHASE(PHASE), .PHASE_STB(PHASE_STB),
        .RUNNING(RUNNING), .HALTED(HALTED), .TIMEOUT(TIMEOUT), .INSTR_CNT(INSTR_CNT)
    );

    // Narrow-counter instance shares the stimulus to exercise wrap-around.
    phase_sequencer #(.WAIT_MAX(WAIT_MAX), .ICOUNT_W(2)) dut_w2 (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .STEP_MODE(STEP_MODE), .STEP(STEP),
        .MEM_RDY(MEM_RDY), .HALT_REQ(HALT_REQ), .PHASE(b_phase), .PHASE_STB(b_stb),
        .RUNNING(b_running), .HALTED(b_halted), .TIMEOUT(b_timeout), .INSTR_CNT(b_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h at t=%0t", tag, obs, exp, $time);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_cnt();
        check("instr_cnt", 32'(INSTR_CNT), 32'(exp_cnt & 'hFFFF));
        check("instr_cnt_w2", 32'(b_cnt), 32'(exp_cnt % 4));
    endtask

    // st: 0 = IDLE, 1 = RUN (first cycle of a fresh FETCH), 2 = HALT
    task automatic check_state(input int st);
        check("running", 32'(RUNNING), 32'(st == 1));
        check("halted", 32'(HALTED), 32'(st == 2));
        check("phase_boundary", 32'(PHASE), 32'd0);
        check("stb_boundary", 32'(PHASE_STB), 32'(st == 1));
        check("timeout", 32'(TIMEOUT), 32'(exp_to));
        check_cnt();
    endtask

    // Runs one instruction starting in its first FETCH cycle. sf/se are requested stall
    // cycles in FETCH/EXECUTE; en_b/sm_b are the EN/STEP_MODE values at the UPDATE cycle;
    // halt_ph is the phase (0..3) whose first cycle carries a HALT_REQ pulse, or -1.
    task automatic do_instr(input int sf, input int se, input bit en_b, input bit sm_b,
                            input int halt_ph);
        int q[$];
        int eff_f, eff_e, j, st;
`ifdef PHASER_WAIT_EN
        eff_f = sf;
        eff_e = se;
`else
        eff_f = 0;
        eff_e = 0;
`endif
        for (int i = 0; i <= eff_f; i++) q.push_back(0);
        q.push_back(1);
        for (int i = 0; i <= eff_e; i++) q.push_back(2);
        q.push_back(3);
        j = 0;
        for (int k = 0; k < q.size(); k++) begin
            j = (k > 0 && q[k] == q[k-1]) ? j + 1 : 0;
            check("phase", 32'(PHASE), 32'(q[k]));
            check("phase_stb", 32'(PHASE_STB), 32'(j == 0));
            check("running_mid", 32'(RUNNING), 32'd1);
            check("halted_mid", 32'(HALTED), 32'd0);
            check("timeout_mid", 32'(TIMEOUT), 32'(exp_to));
            check_cnt();
            if (q[k] == 0)      MEM_RDY = (j >= sf);
            else if (q[k] == 2) MEM_RDY = (j >= se);
            else                MEM_RDY = 1'($urandom);
            HALT_REQ = (q[k] == halt_ph) && (j == 0);
            STEP     = 1'($urandom);
            if (q[k] == 3) begin
                EN        = en_b;
                STEP_MODE = sm_b;
            end else begin
                EN        = 1'($urandom);
                STEP_MODE = 1'($urandom);
            end
            step();
        end
        HALT_REQ  = 1'b0;
        STEP      = 1'b0;
        EN        = en_b;
        STEP_MODE = sm_b;
        exp_cnt++;
        if (halt_ph >= 0)          st = 2;
        else if (!en_b || sm_b)    st = 0;
        else                       st = 1;
        check_state(st);
    endtask

    task automatic do_reset();
        RST_N     = 1'b0;
        EN        = 1'b0;
        STEP_MODE = 1'b0;
        STEP      = 1'b0;
        HALT_REQ  = 1'b0;
        MEM_RDY   = 1'b1;
        exp_cnt   = 0;
        exp_to    = 1'b0;
        step();
        step();
        check_state(0);
        RST_N = 1'b1;
    endtask

    initial begin
        #2;
        do_reset();

        // IDLE holds without a run request
        step();
        check_state(0);
        EN = 1'b1;
        STEP_MODE = 1'b1;
        step();
        step();
        check_state(0);

        // Free run
        STEP_MODE = 1'b0;
        step();
        for (int n = 0; n < 3; n++) do_instr(0, 0, 1'b1, 1'b0, -1);

        // Randomized stalls within budget, then directed short and maximal stalls
        for (int n = 0; n < 8; n++)
            do_instr(int'($urandom_range(0, WAIT_MAX)), int'($urandom_range(0, WAIT_MAX)),
                     1'b1, 1'b0, -1);
        do_instr(0, 2, 1'b1, 1'b0, -1);
        do_instr(WAIT_MAX, WAIT_MAX, 1'b1, 1'b0, -1);

        // Pause at the boundary when EN drops
        do_instr(1, 1, 1'b0, 1'b0, -1);
        step();
        step();
        check_state(0);

        // Single step
        EN = 1'b1;
        STEP_MODE = 1'b1;
        step();
        check_state(0);
        for (int n = 0; n < 2; n++) begin
            STEP = 1'b1;
            step();
            STEP = 1'b0;
            do_instr(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b1, 1'b1, -1);
            step();
            check_state(0);
        end

        // Halt request in DECODE, then HALT ignores all controls
        STEP_MODE = 1'b0;
        step();
        do_instr(0, 1, 1'b1, 1'b0, 1);
        for (int n = 0; n < 6; n++) begin
            EN        = 1'($urandom);
            STEP      = 1'($urandom);
            STEP_MODE = 1'($urandom);
            HALT_REQ  = 1'($urandom);
            MEM_RDY   = 1'($urandom);
            step();
            check_state(2);
        end

        // Halt request in the UPDATE cycle itself
        do_reset();
        EN = 1'b1;
        step();
        do_instr(0, 0, 1'b1, 1'b0, 3);

        // Asynchronous reset during EXECUTE
        do_reset();
        EN = 1'b1;
        step();
        do_instr(0, 0, 1'b1, 1'b0, -1);
        MEM_RDY = 1'b1;
        step();
        step();
        check("phase_pre_reset", 32'(PHASE), 32'd2);
        #3 RST_N = 1'b0;
        #1;
        exp_cnt = 0;
        check_state(0);
        step();
        RST_N = 1'b1;
        EN = 1'b1;
        step();
        do_instr(0, 0, 1'b1, 1'b0, -1);

`ifdef PHASER_WAIT_EN
        // FETCH timeout together with a halt request on the halting edge
        for (int k = 0; k <= WAIT_MAX; k++) begin
            check("phase_to", 32'(PHASE), 32'd0);
            check("stb_to", 32'(PHASE_STB), 32'(k == 0));
            check("running_to", 32'(RUNNING), 32'd1);
            check("timeout_pre", 32'(TIMEOUT), 32'd0);
            MEM_RDY  = 1'b0;
            HALT_REQ = (k == WAIT_MAX);
            step();
        end
        HALT_REQ = 1'b0;
        exp_to   = 1'b1;
        check_state(2);
        EN = 1'b0;
        step();
        EN = 1'b1;
        step();
        check_state(2);
`else
        // Without wait states MEM_RDY low never stretches a phase
        do_instr(WAIT_MAX, WAIT_MAX, 1'b1, 1'b0, -1);
        MEM_RDY = 1'b0;
        do_instr(0, 0, 1'b1, 1'b0, -1);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Generates the 2-bit instruction PHASE (FETCH, DECODE, EXECUTE, UPDATE) that drives the sequence controller. It controls run, pause, single-step and halt of the RISC core. FETCH and EXECUTE can be stretched by memory wait states, with a timeout that halts the core, and the block counts retired instructions. It sits between the top-level run controls and the sequence controller, and is the only source of PHASE in the design.

## Interface
Parameters:
- WAIT_MAX, 7: maximum stall cycles allowed per FETCH/EXECUTE phase (≥0).
- ICOUNT_W, 16: width of the retired-instruction counter.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- EN  in  1  run enable; deassertion pauses at the next instruction boundary.
- STEP_MODE  in  1  1 = execute one instruction per STEP.
- STEP  in  1  single-step request, sampled only in IDLE.
- MEM_RDY  in  1  memory ready; gates exit from FETCH and EXECUTE.
- HALT_REQ  in  1  halt after the current instruction; latched while in RUN.
- PHASE  out  2  FETCH=00, DECODE=01, EXECUTE=10, UPDATE=11.
- PHASE_STB  out  1  one-cycle pulse in the first cycle of each new phase.
- RUNNING  out  1  state is RUN.
- HALTED  out  1  state is HALT.
- TIMEOUT  out  1  sticky flag: wait-state timeout occurred.
- INSTR_CNT  out  ICOUNT_W  retired instructions; wraps modulo 2^ICOUNT_W.

## Operation
- **States:** IDLE, RUN, HALT.
- **Reset values:**
  - state IDLE, PHASE=00, PHASE_STB=0, RUNNING=0, HALTED=0, TIMEOUT=0, INSTR_CNT=0.
  - halt-pending flag and wait counter cleared.
- **IDLE:**
  - PHASE held at FETCH.
  - Go to RUN when EN=1 and (STEP_MODE=0 or STEP=1).
  - PHASE_STB pulses in the first RUN cycle.
- **RUN, phase advance:** FETCH→DECODE→EXECUTE→UPDATE→FETCH, one phase per cycle.
- **RUN, wait states:** FETCH and EXECUTE advance only when MEM_RDY=1.
- **RUN, other inputs:**
  - HALT_REQ=1 in any RUN cycle sets halt-pending.
  - STEP is ignored in RUN.
- **Instruction boundary (UPDATE→FETCH):**
  - INSTR_CNT increments.
  - Next state, in priority order: halt-pending → HALT; EN=0 → IDLE; STEP_MODE=1 → IDLE; otherwise remain in RUN.
- **Wait counter:**
  - Cleared on entry to every phase.
  - MEM_RDY=0 with count<WAIT_MAX: count increments and the phase holds.
  - MEM_RDY=0 with count==WAIT_MAX: TIMEOUT is set, the state goes to HALT and PHASE is forced to FETCH.
  - The instruction does not retire (no INSTR_CNT increment).
- **HALT:**
  - Terminal; PHASE=FETCH.
  - EN, STEP and HALT_REQ are ignored; only RST_N exits.
- **Simultaneous events:**
  - HALT_REQ in the UPDATE cycle itself takes effect at that boundary.
  - Timeout and HALT_REQ together: HALT, with TIMEOUT=1.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- EN rising in IDLE: RUNNING=1 and PHASE_STB=1 one cycle later.
- No stalls: 4 cycles per instruction. Each stall cycle adds 1.
- Longest single phase: WAIT_MAX+1 cycles before the halting edge.
- INSTR_CNT updates in the same cycle that PHASE returns to FETCH.
- RST_N assertion mid-instruction clears all state immediately, without waiting for a clock; operation resumes from IDLE after release.

## Configuration
- PHASER_WAIT_EN defined:
  - MEM_RDY stalls, the wait counter and timeout are implemented as above.
- PHASER_WAIT_EN undefined:
  - MEM_RDY is ignored and every phase lasts exactly 1 cycle.
  - The wait counter is removed, TIMEOUT is tied to 0, and WAIT_MAX is unused.

## Structure
- Shared package phase_pkg holds:
  - phase_t, a 2-bit enum FETCH/DECODE/EXECUTE/UPDATE, also imported by the sequence controller;
  - seq_state_t, an enum IDLE/RUN/HALT.
- Sub-module wait_timer:
  - counter of width $clog2(WAIT_MAX+1), with clear, increment and expired output;
  - instantiated only under PHASER_WAIT_EN.

## Test plan
- **Free run:** reset; EN=1, MEM_RDY=1, STEP_MODE=0.
  - PHASE 00,01,10,11 repeating every cycle from the first RUN cycle.
  - INSTR_CNT=3 after 12 RUN cycles; PHASE_STB high every cycle.
- **Short stall:** MEM_RDY=0 for 2 cycles on entry to EXECUTE, WAIT_MAX=7.
  - EXECUTE lasts 3 cycles and TIMEOUT stays 0.
  - PHASE_STB pulses only on entry to EXECUTE.
- **Timeout:** MEM_RDY held 0 in FETCH, WAIT_MAX=7.
  - FETCH lasts 8 cycles, then HALTED=1, TIMEOUT=1, PHASE=00, INSTR_CNT unchanged.
- **Single step:** STEP_MODE=1, one STEP pulse.
  - Exactly 4 phases, then IDLE, INSTR_CNT+1.
  - A STEP pulse during RUN has no effect.
- **Halt request:** HALT_REQ pulse during DECODE.
  - The instruction completes UPDATE, then HALTED=1.
  - EN toggling and STEP have no effect until RST_N.
- **Reset and wrap:** RST_N low during EXECUTE gives PHASE=00 and INSTR_CNT=0 before the next clock edge. Separately, with ICOUNT_W=2, INSTR_CNT wraps 3→0 on the 4th retired instruction.
